// File: rtl/awb_pkg.sv
// Shared types, constants and arithmetic helpers for the auto-white-balance gain path.
package awb_pkg;

  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned ACC_W_DEF  = 32;
  localparam int unsigned FRAC_DEF   = 12;
  localparam int unsigned GAIN_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } div_state_e;

  function automatic logic [31:0] gain_unity(input int unsigned frac);
    return 32'(1) << frac;
  endfunction

  localparam logic [GAIN_W_DEF-1:0] GAIN_UNITY = GAIN_W_DEF'(gain_unity(FRAC_DEF));

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] max);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[63:0];
  endfunction

  function automatic logic [63:0] clamp(input logic [63:0] v, input logic [63:0] max);
    return (v > max) ? max : v;
  endfunction

  // One IIR step: cur + ((tgt - cur) >>> sh), evaluated as signed so it can move both ways.
  function automatic logic [31:0] iir_step(input logic [31:0] cur, input logic [31:0] tgt,
                                           input int unsigned sh);
    logic signed [32:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    diff = diff >>> sh;
    return 32'($signed({1'b0, cur}) + diff);
  endfunction

endpackage

// File: rtl/awb_div_seq.sv
// Restoring unsigned sequential divider: one quotient bit per cycle, IDLE -> RUN -> DONE.
module awb_div_seq
  import awb_pkg::*;
#(
  parameter int unsigned NUM_W = 44,
  parameter int unsigned DEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo
);

  localparam int unsigned CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  div_state_e       state, state_nxt;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic [DEN_W:0]   rem_sh;
  logic [DEN_W:0]   rem_sub;
  logic             fits;

  always_comb begin
    state_nxt = state;
    rem_sh    = {rem, quo[NUM_W-1]};
    rem_sub   = rem_sh - {1'b0, den_q};
    fits      = (rem_sh >= {1'b0, den_q});
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(NUM_W - 1)) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // quo doubles as the numerator shift register; quotient bits enter from the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      quo   <= '0;
      den_q <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            quo   <= num;
            den_q <= den;
            rem   <= '0;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          rem <= fits ? DEN_W'(rem_sub) : DEN_W'(rem_sh);
          quo <= {quo[NUM_W-2:0], fits};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/awb_gain_ctrl.sv
// Gray-world AWB: per-frame RGB sums, sequential R/B gain division, IIR smoothing,
// frame-boundary gain update and a 2-cycle gain-applying pixel path.
module awb_gain_ctrl
  import awb_pkg::*;
#(
  parameter int unsigned       DW        = DW_DEF,
  parameter int unsigned       ACC_W     = ACC_W_DEF,
  parameter int unsigned       FRAC      = FRAC_DEF,
  parameter int unsigned       GAIN_W    = GAIN_W_DEF,
  parameter logic [GAIN_W-1:0] MAX_GAIN  = GAIN_W'(16'hFFFF),
  parameter int unsigned       SMOOTH_SH = 2
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_mode,
  input  logic              I_freeze,
  input  logic [GAIN_W-1:0] I_man_r_gain,
  input  logic [GAIN_W-1:0] I_man_b_gain,
  input  logic              I_awb_vs,
  input  logic              I_awb_hs,
  input  logic              I_awb_de,
  input  logic [3*DW-1:0]   I_awb_rgb,
  output logic              O_awb_vs,
  output logic              O_awb_hs,
  output logic              O_awb_de,
  output logic [3*DW-1:0]   O_awb_rgb,
  output logic [GAIN_W-1:0] O_r_gain,
  output logic [GAIN_W-1:0] O_b_gain,
  output logic              O_stat_valid,
  output logic              O_busy
);

  localparam int unsigned       NUM_W    = ACC_W + FRAC;
  localparam int unsigned       PW       = DW + GAIN_W;
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(gain_unity(FRAC));
  localparam logic [63:0]       ACC_MAX  = (64'(1) << ACC_W) - 64'(1);
  localparam logic [63:0]       GAIN_LIM = 64'(MAX_GAIN);

  logic              vs_d, fb;
  logic [DW-1:0]     pix_r, pix_g, pix_b;
  logic [ACC_W-1:0]  acc_r, acc_g, acc_b;
  logic              div_start, busy_r, busy_b, done_r, done_b, div_done;
  logic [NUM_W-1:0]  quo_r, quo_b;
  logic              den0_r, den0_b;
  logic [GAIN_W-1:0] tgt_r, tgt_b;
  logic [GAIN_W-1:0] smooth_r, smooth_b, smooth_r_nxt, smooth_b_nxt;
  logic [GAIN_W-1:0] act_r, act_b;
  logic              s1_vs, s1_hs, s1_de;
  logic [PW-1:0]     s1_pr, s1_pb;
  logic [DW-1:0]     s1_g;
  logic [PW-1:0]     pr_sh, pb_sh;
  logic [DW-1:0]     r_sat, b_sat;

  assign {pix_r, pix_g, pix_b} = I_awb_rgb;
  assign fb        = vs_d & ~I_awb_vs;
  assign div_start = fb & ~(busy_r | busy_b);
  assign div_done  = done_r & done_b;

  // Frame statistics; the sums restart at every frame boundary.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_d   <= 1'b0;
      acc_r  <= '0;
      acc_g  <= '0;
      acc_b  <= '0;
      den0_r <= 1'b0;
      den0_b <= 1'b0;
    end else begin
      vs_d <= I_awb_vs;
      if (div_start) begin
        den0_r <= (acc_r == '0);
        den0_b <= (acc_b == '0);
      end
      if (fb) begin
        acc_r <= '0;
        acc_g <= '0;
        acc_b <= '0;
      end else if (I_awb_hs && I_awb_de) begin
        acc_r <= ACC_W'(sat_add(64'(acc_r), 64'(pix_r), ACC_MAX));
        acc_g <= ACC_W'(sat_add(64'(acc_g), 64'(pix_g), ACC_MAX));
        acc_b <= ACC_W'(sat_add(64'(acc_b), 64'(pix_b), ACC_MAX));
      end
    end
  end

  awb_div_seq #(.NUM_W(NUM_W), .DEN_W(ACC_W)) u_div_r (
    .clk(I_clk), .rst_n(I_rst_n), .start(div_start),
    .num({acc_g, {FRAC{1'b0}}}), .den(acc_r),
    .busy(busy_r), .done(done_r), .quo(quo_r)
  );

  awb_div_seq #(.NUM_W(NUM_W), .DEN_W(ACC_W)) u_div_b (
    .clk(I_clk), .rst_n(I_rst_n), .start(div_start),
    .num({acc_g, {FRAC{1'b0}}}), .den(acc_b),
    .busy(busy_b), .done(done_b), .quo(quo_b)
  );

  always_comb begin
    tgt_r        = den0_r ? MAX_GAIN : GAIN_W'(clamp(64'(quo_r), GAIN_LIM));
    tgt_b        = den0_b ? MAX_GAIN : GAIN_W'(clamp(64'(quo_b), GAIN_LIM));
    smooth_r_nxt = smooth_r;
    smooth_b_nxt = smooth_b;
    if (div_done && !I_mode) begin
      smooth_r_nxt = GAIN_W'(iir_step(32'(smooth_r), 32'(tgt_r), SMOOTH_SH));
      smooth_b_nxt = GAIN_W'(iir_step(32'(smooth_b), 32'(tgt_b), SMOOTH_SH));
    end
  end

  // Active gains only move at a frame boundary so a frame never sees two gain sets.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      smooth_r <= UNITY;
      smooth_b <= UNITY;
      act_r    <= UNITY;
      act_b    <= UNITY;
    end else begin
      smooth_r <= smooth_r_nxt;
      smooth_b <= smooth_b_nxt;
      if (fb && !I_freeze) begin
        if (I_mode) begin
          act_r    <= I_man_r_gain;
          act_b    <= I_man_b_gain;
          smooth_r <= I_man_r_gain;
          smooth_b <= I_man_b_gain;
        end else begin
          act_r <= smooth_r_nxt;
          act_b <= smooth_b_nxt;
        end
      end
    end
  end

  always_comb begin
    pr_sh = s1_pr >> FRAC;
    pb_sh = s1_pb >> FRAC;
    r_sat = (|pr_sh[PW-1:DW]) ? {DW{1'b1}} : pr_sh[DW-1:0];
    b_sat = (|pb_sh[PW-1:DW]) ? {DW{1'b1}} : pb_sh[DW-1:0];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1_vs     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_de     <= 1'b0;
      s1_pr     <= '0;
      s1_pb     <= '0;
      s1_g      <= '0;
      O_awb_vs  <= 1'b0;
      O_awb_hs  <= 1'b0;
      O_awb_de  <= 1'b0;
      O_awb_rgb <= '0;
    end else begin
      s1_vs     <= I_awb_vs;
      s1_hs     <= I_awb_hs;
      s1_de     <= I_awb_de;
      s1_pr     <= PW'(pix_r) * PW'(act_r);
      s1_pb     <= PW'(pix_b) * PW'(act_b);
      s1_g      <= pix_g;
      O_awb_vs  <= s1_vs;
      O_awb_hs  <= s1_hs;
      O_awb_de  <= s1_de;
      O_awb_rgb <= {r_sat, s1_g, b_sat};
    end
  end

  assign O_r_gain     = act_r;
  assign O_b_gain     = act_b;
  assign O_busy       = busy_r | busy_b;
  assign O_stat_valid = div_done;

endmodule

// File: doc/awb_gain_ctrl.md
Name: awb_gain_ctrl

Overview:
Parametrised gray-world auto-white-balance block for the DVP video path. Per frame it accumulates R/G/B sums over active pixels, then computes red and blue gains relative to green with a sequential divider. Gains are temporally smoothed, can be overridden manually or frozen, and are applied to the pixel stream tear-free at frame boundaries. Sits between the demosaic/RGB stage and the downstream scaler/mux.

Parameters:
DW, 8, bits per colour channel
ACC_W, 32, per-channel accumulator width; sums saturate at 2^ACC_W-1
FRAC, 12, fractional bits of gains (unity gain = 1<<FRAC)
GAIN_W, 16, gain register width
MAX_GAIN, 16'hFFFF, upper clamp applied to computed gains
SMOOTH_SH, 2, IIR shift; 0 means the target gain is applied directly

Ports:
I_clk  in  1  clock
I_rst_n  in  1  reset, asynchronous, active-low
I_mode  in  1  0 = auto, 1 = manual gains
I_freeze  in  1  1 = hold the active gains (accumulation continues)
I_man_r_gain  in  GAIN_W  manual red gain, FRAC fractional bits
I_man_b_gain  in  GAIN_W  manual blue gain
I_awb_vs / I_awb_hs / I_awb_de  in  1 each  input sync signals
I_awb_rgb  in  3*DW  {R,G,B}
O_awb_vs / O_awb_hs / O_awb_de  out  1 each  syncs delayed 2 cycles
O_awb_rgb  out  3*DW  corrected pixel
O_r_gain / O_b_gain  out  GAIN_W  active gains
O_stat_valid  out  1  1-cycle pulse when new target gains are computed
O_busy  out  1  divider running

Behaviour:
- Reset values: all outputs 0 except O_r_gain = O_b_gain = 1<<FRAC. Internal pending, smoothed and active gains are also 1<<FRAC. The divider returns to IDLE.
- Frame boundary (fb): fb is the falling edge of I_awb_vs, detected with one registered copy of vs.
- Accumulation: while I_awb_hs & I_awb_de, add each channel to its sum, saturating at 2^ACC_W-1. On fb, the sums are cleared. A pixel on the fb cycle is discarded.
- Snapshot: on fb with divider IDLE, copy the sums to snapshot registers and start the divider. On fb with divider busy, drop the snapshot; no O_stat_valid is produced for that frame.
- Divider FSM states: IDLE -> RUN (NUM_W = ACC_W+FRAC cycles, one quotient bit per cycle) -> DONE (1 cycle) -> IDLE.
  - O_busy = (state != IDLE).
  - Two dividers run in parallel: target_r = (Gsum<<FRAC)/Rsum and target_b = (Gsum<<FRAC)/Bsum.
  - A zero denominator gives a quotient of MAX_GAIN.
  - Every quotient is clamped to min(MAX_GAIN, 2^GAIN_W-1).
- Smoothing (in DONE, auto mode only): smooth <= smooth + ((target - smooth) >>> SMOOTH_SH), using signed GAIN_W+1 arithmetic. O_stat_valid pulses in the same cycle.
- Active gain update, at fb only:
  - I_freeze = 1: hold.
  - Manual mode: active <= manual inputs, and smooth <= manual inputs, so a return to auto starts from the manual values.
  - Auto mode: active <= smooth.
  - Consequence: stats from frame N take effect on frame N+2.
- Pixel path, 2-cycle latency:
  - Stage 1 registers pixel and syncs, and forms R*r_gain, G<<FRAC, B*b_gain.
  - Stage 2 shifts right by FRAC. Any bit at or above DW saturates to 2^DW-1.
  - Green passes with unity gain.
  - Syncs get an identical 2-cycle delay.
- Reset mid-division aborts the division; the gains return to unity.
- Simultaneous DONE and fb: smoothing update happens first, and active picks up the new smooth value in the same cycle.

Decomposition:
- Shared package awb_pkg holds: gain unity constant, FSM state enum (IDLE/RUN/DONE), saturating-add and clamp functions.
- Sub-module awb_div_seq: restoring unsigned sequential divider.
  - Parameters NUM_W and DEN_W.
  - Ports start/done/quo/busy.
  - Instantiated twice.

Test Plan:
1. DW=8, FRAC=12, SMOOTH_SH=0, auto mode, 4x4 frames of constant (64,128,32) -> after frame N, O_stat_valid pulses once. At the fb of frame N+1, O_r_gain=0x2000 and O_b_gain=0x4000. In frame N+2, output pixels are (128,128,128).
2. Frame with R=0, G=100, B=100 -> target_r=0xFFFF and b_gain=0x1000. Next applied frame: input (200,100,100) gives output (255,100,100).
3. SMOOTH_SH=2, constant frames with target_r=0x2000 -> successive O_r_gain values 0x1400, 0x1700, 0x1940.
4. I_mode=1 with man_r=0x0800 and man_b=0x1800 -> at the next fb, the gains load; input (100,100,100) gives (50,100,150). With I_freeze=1 and new manual values, the gains stay unchanged.
5. Vs pulses spaced closer than NUM_W+2 cycles -> the second snapshot is dropped, only one O_stat_valid pulse, and O_busy stays continuous.
6. Assert I_rst_n low while O_busy=1 -> all outputs 0, gains 0x1000, O_busy=0. The next full frame produces correct gains.
